// File: rtl/input_port_buffer.sv
// rtl/input_port_buffer.sv - per-port router input FIFO with route latch and allocator requests
module input_port_buffer #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int FLIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              buf_full,
  output logic [FLIT_W-1:0] head_flit,
  input  logic [4:0]        route_onehot_in,
  output logic [4:0]        req,
  input  logic              grant,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_out_valid,
  output logic [PTR_W:0]    occupancy,
  output logic              overflow_err,
  output logic              proto_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [FLIT_W-1:0]   mem_q [DEPTH];
  logic [FLIT_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic                buf_full_q, buf_full_d;
  logic [4:0]          route_q, route_d;
  logic [FLIT_W-1:0]   flit_out_q, flit_out_d;
  logic                flit_out_valid_q, flit_out_valid_d;
  logic                overflow_q, overflow_d;
  logic                proto_q, proto_d;

  logic                non_empty;
  logic                head_is_hdr;
  logic                head_is_tail;
  logic                route_onehot;
  logic                wr_en;
  logic                fwd_pop;
  logic                drop_pop;
  logic                latch_route;
  logic                pop;

  // Head-flit classification and write qualification
  always_comb begin
    non_empty    = (count_q != '0);
    head_flit    = non_empty ? mem_q[rd_ptr_q] : '0;
    head_is_hdr  = head_flit[7];
    head_is_tail = head_flit[6];
    route_onehot = (route_onehot_in != 5'd0) &&
                   ((route_onehot_in & (route_onehot_in - 5'd1)) == 5'd0);
    wr_en        = flit_in_valid && !buf_full_q;
  end

  // State register plus all datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      buf_full_q       <= 1'b0;
      route_q          <= 5'd0;
      flit_out_q       <= '0;
      flit_out_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      proto_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      buf_full_q       <= buf_full_d;
      route_q          <= route_d;
      flit_out_q       <= flit_out_d;
      flit_out_valid_q <= flit_out_valid_d;
      overflow_q       <= overflow_d;
      proto_q          <= proto_d;
    end
  end

  // Flit storage; contents are meaningless once pointers are reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Next-state: IDLE latches a valid route, ACTIVE returns on a forwarded tail
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (latch_route) state_d = ACTIVE;
      ACTIVE: if (fwd_pop && head_is_tail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: requests, forwarding pops, framing drops and route latching
  always_comb begin
    req         = 5'd0;
    fwd_pop     = 1'b0;
    drop_pop    = 1'b0;
    latch_route = 1'b0;
    case (state_q)
      IDLE: begin
        if (non_empty) begin
          if (head_is_hdr && route_onehot) latch_route = 1'b1;
          else                             drop_pop    = 1'b1;
        end
      end
      ACTIVE: begin
        if (non_empty) req = route_q;
        fwd_pop = grant && (req != 5'd0);
      end
      default: ;
    endcase
  end

  // FIFO pointers, occupancy, forwarded flit, route register and sticky errors
  always_comb begin
    pop              = fwd_pop || drop_pop;
    mem_d            = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = flit_in;
    wr_ptr_d         = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d         = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d          = count_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};
    buf_full_d       = (count_d == FULL_CNT);
    flit_out_d       = fwd_pop ? head_flit : flit_out_q;
    flit_out_valid_d = fwd_pop;
    route_d          = route_q;
    if (latch_route) route_d = route_onehot_in;
    else if (fwd_pop && head_is_tail) route_d = 5'd0;
    overflow_d       = overflow_q || (flit_in_valid && buf_full_q);
    proto_d          = proto_q || drop_pop;
  end

  assign buf_full       = buf_full_q;
  assign flit_out       = flit_out_q;
  assign flit_out_valid = flit_out_valid_q;
  assign occupancy      = count_q;
  assign overflow_err   = overflow_q;
  assign proto_err      = proto_q;

endmodule
